// File: rtl/bbuf2ddr_if.sv
// DDR write-stream handshake: bbuf2ddr drives beats (master), the DDR writer accepts them (slave).
interface bbuf2ddr_if #(
    parameter int unsigned DDR_W = 512
);
    logic [DDR_W-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/bbuf2ddr.sv
// Drains up to 4 PE bias/accumulate buffer groups to DDR as DDR_W beats through a small output FIFO.
// Build macro BBUF2DDR_RELU_EN: negative lanes are zeroed before the FIFO push.
module bbuf2ddr #(
    parameter int unsigned DDR_W      = 512,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned BATCH      = 32,
    parameter int unsigned BUF_DEPTH  = 256,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic                                done,
    input  logic [2:0]                          conf_grp_num,
    input  logic [$clog2(BUF_DEPTH):0]          conf_word_num,
    output logic [$clog2(BUF_DEPTH)-1:0]        bbuf_rd_addr,
    output logic                                bbuf_rd_en,
    input  logic [3:0][DATA_W*BATCH-1:0]        bbuf_rd_data,
    bbuf2ddr_if.master                          ddr
);

    localparam int unsigned ADDR_W = $clog2(BUF_DEPTH);
    localparam int unsigned WN_W   = ADDR_W + 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned SUM_W  = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state;
    logic [2:0]         grp_num_q;
    logic [WN_W-1:0]    word_num_q;
    logic [1:0]         nxt_grp;
    logic [ADDR_W-1:0]  nxt_addr;
    logic               issued_all;
    logic [1:0]         grp_q;
    logic [1:0]         grp_d;
    logic               push_v;
    logic [DDR_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic [2:0]         conf_grp_c;
    logic [2:0]         lim_grp;
    logic [WN_W-1:0]    lim_word;
    logic [1:0]         cur_grp;
    logic [1:0]         adv_grp;
    logic [ADDR_W-1:0]  cur_addr;
    logic [ADDR_W-1:0]  adv_addr;
    logic               grp_end;
    logic               is_last;
    logic               push;
    logic               pop;
    logic               space;
    logic               issue;
    logic [CNT_W-1:0]   cnt_next;
    logic [DDR_W-1:0]   push_data;

    // Read sequencing: address outer, group inner; IDLE looks at the live config so the first read issues on start.
    always_comb begin
        conf_grp_c = (conf_grp_num == 3'd0 || conf_grp_num > 3'd4) ? 3'd4 : conf_grp_num;
        lim_grp    = grp_num_q;
        lim_word   = word_num_q;
        cur_grp    = nxt_grp;
        cur_addr   = nxt_addr;
        if (state == IDLE) begin
            lim_grp  = conf_grp_c;
            lim_word = conf_word_num;
            cur_grp  = 2'd0;
            cur_addr = '0;
        end
        grp_end  = ({1'b0, cur_grp} == lim_grp - 3'd1);
        is_last  = grp_end && ({1'b0, cur_addr} == lim_word - WN_W'(1));
        adv_grp  = grp_end ? 2'd0 : cur_grp + 2'd1;
        adv_addr = grp_end ? cur_addr + ADDR_W'(1) : cur_addr;
        if (is_last) begin
            adv_grp  = cur_grp;
            adv_addr = cur_addr;
        end
    end

    // FIFO occupancy and read-issue gating; the read still in flight reserves its slot.
    always_comb begin
        push     = push_v;
        pop      = ddr.valid & ddr.ready;
        cnt_next = count + CNT_W'(push) - CNT_W'(pop);
        space    = (SUM_W'(cnt_next) + SUM_W'(bbuf_rd_en)) < SUM_W'(FIFO_DEPTH);
        issue    = ((state == IDLE) && start && (lim_word != '0)) ||
                   ((state == RUN) && !issued_all && space);
    end

    always_comb begin
        push_data = DDR_W'(bbuf_rd_data[grp_d]);
`ifdef BBUF2DDR_RELU_EN
        for (int i = 0; i < int'(BATCH); i++) begin
            if (push_data[i*DATA_W + DATA_W - 1]) begin
                push_data[i*DATA_W +: DATA_W] = '0;
            end
        end
`endif
    end

    assign ddr.data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            done         <= 1'b0;
            bbuf_rd_en   <= 1'b0;
            bbuf_rd_addr <= '0;
            ddr.valid    <= 1'b0;
            grp_num_q    <= 3'd0;
            word_num_q   <= '0;
            nxt_grp      <= 2'd0;
            nxt_addr     <= '0;
            issued_all   <= 1'b0;
            grp_q        <= 2'd0;
            grp_d        <= 2'd0;
            push_v       <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            done       <= 1'b0;
            bbuf_rd_en <= 1'b0;
            push_v     <= bbuf_rd_en;
            grp_d      <= grp_q;
            count      <= cnt_next;
            ddr.valid  <= (cnt_next != '0);

            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            if (issue) begin
                bbuf_rd_en   <= 1'b1;
                bbuf_rd_addr <= cur_addr;
                grp_q        <= cur_grp;
                nxt_grp      <= adv_grp;
                nxt_addr     <= adv_addr;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        grp_num_q  <= lim_grp;
                        word_num_q <= lim_word;
                        if (lim_word == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            issued_all <= is_last;
                            state      <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (issued_all) begin
                        state <= DRAIN;
                    end else if (issue && is_last) begin
                        issued_all <= 1'b1;
                        state      <= DRAIN;
                    end
                end
                // Finish in the cycle right after the last handshake, once nothing is pending.
                DRAIN: begin
                    if (cnt_next == '0 && !bbuf_rd_en) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    issued_all <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
